// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory request/ready channel between the fetch unit (master) and memory (slave).
interface pc_fetch_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic [31:0]     imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// Next-PC computation, architectural PC register and instruction-fetch handshake.
// Optional macro PERF_CNT_EN adds retire_cnt/redirect_cnt performance counters.
module pc_fetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              PCAsrc,
    input  logic              PCBsrc,
    input  logic [XLEN-1:0]   imm,
    input  logic [XLEN-1:0]   rs1,
    input  logic              commit,
    pc_fetch_unit_if.master   imem,
    output logic [XLEN-1:0]   pc,
    output logic [31:0]       instr,
    output logic              instr_valid,
    output logic              misalign
`ifdef PERF_CNT_EN
    ,
    output logic [63:0]       retire_cnt,
    output logic [31:0]       redirect_cnt
`endif
);

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_BOOT,
        S_FETCH,
        S_EXEC,
        S_TRAP
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     instr_q, instr_d;
    logic            valid_q, valid_d;
    logic            req_q, req_d;
    logic            misalign_q, misalign_d;
    logic [XLEN-1:0] base, offset, target;

`ifdef PERF_CNT_EN
    logic [63:0] retire_q, retire_d;
    logic [31:0] redirect_q, redirect_d;
`endif

    // Branch/jump target; jalr clears bit 0 before the alignment check.
    always_comb begin
        offset = PCAsrc ? imm : XLEN'(4);
        base   = PCBsrc ? rs1 : pc_q;
        target = base + offset;
        if (PCAsrc && PCBsrc) begin
            target[0] = 1'b0;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        valid_d    = valid_q;
        req_d      = 1'b0;
        misalign_d = misalign_q;
`ifdef PERF_CNT_EN
        retire_d   = retire_q;
        redirect_d = redirect_q;
`endif
        unique case (state_q)
            S_BOOT: begin
                state_d = S_FETCH;
                req_d   = 1'b1;
            end
            S_FETCH: begin
                if (imem.imem_ready) begin
                    instr_d = imem.imem_rdata;
                    valid_d = 1'b1;
                    state_d = S_EXEC;
                end else begin
                    req_d = 1'b1;
                end
            end
            S_EXEC: begin
                if (commit) begin
                    valid_d = 1'b0;
                    if (target[1]) begin
                        misalign_d = 1'b1;
                        state_d    = S_TRAP;
                    end else begin
                        pc_d    = target;
                        req_d   = 1'b1;
                        state_d = S_FETCH;
`ifdef PERF_CNT_EN
                        retire_d = retire_q + 64'd1;
                        if (PCAsrc || PCBsrc) begin
                            redirect_d = redirect_q + 32'd1;
                        end
`endif
                    end
                end
            end
            S_TRAP: begin
                valid_d = 1'b0;
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase
    end

    // Outputs are all registered, so reset clears them (including imem_req) asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_BOOT;
            pc_q       <= RESET_PC;
            instr_q    <= NOP_INSTR;
            valid_q    <= 1'b0;
            req_q      <= 1'b0;
            misalign_q <= 1'b0;
`ifdef PERF_CNT_EN
            retire_q   <= 64'd0;
            redirect_q <= 32'd0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            valid_q    <= valid_d;
            req_q      <= req_d;
            misalign_q <= misalign_d;
`ifdef PERF_CNT_EN
            retire_q   <= retire_d;
            redirect_q <= redirect_d;
`endif
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc_q;
    assign pc             = pc_q;
    assign instr          = instr_q;
    assign instr_valid    = valid_q;
    assign misalign       = misalign_q;
`ifdef PERF_CNT_EN
    assign retire_cnt     = retire_q;
    assign redirect_cnt   = redirect_q;
`endif

endmodule
